stack_op_ctrl: RTL

Client-side controller that drives the push/pop/tos interface of the 8-bit stack block and executes stack-machine operations on it. It accepts one opcode at a time over a valid/ready handshake and sequences the required stack strobes. It captures popped operands, computes the result and pushes it back. It keeps its own depth count for underflow/overflow detection, and sits between the processor decode stage and the stack.

---
 rtl/stack_pkg.sv | 46 ++++
 rtl/stack_alu.sv | 25 ++
 rtl/stack_op_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared opcodes, state encoding and defaults for the stack-machine controller.
// Also holds the operand-count helper used by the underflow check.
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_TOS  = 3'd7;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POPA = 3'd1;
  localparam logic [2:0] S_CAPA = 3'd2;
  localparam logic [2:0] S_POPB = 3'd3;
  localparam logic [2:0] S_CAPB = 3'd4;
  localparam logic [2:0] S_PUSH = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_POPA = S_POPA,
    ST_CAPA = S_CAPA,
    ST_POPB = S_POPB,
    ST_CAPB = S_CAPB,
    ST_PUSH = S_PUSH,
    ST_DONE = S_DONE
  } state_t;

  // Number of stack words an opcode consumes; anything less on the stack is underflow.
  function automatic logic [1:0] operand_need(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      OP_POP, OP_TOS, OP_NOT: n = 2'd1;
      OP_ADD, OP_SUB, OP_AND: n = 2'd2;
      default:                n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational result unit: a is the old top of stack, b the word beneath it.
module stack_alu
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Modulo-2^WIDTH result selection
  always_comb begin
    o_y = {WIDTH{1'b0}};
    case (i_op)
      OP_ADD:  o_y = i_b + i_a;
      OP_SUB:  o_y = i_b - i_a;
      OP_AND:  o_y = i_b & i_a;
      OP_NOT:  o_y = ~i_a;
      default: o_y = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/stack_op_ctrl.sv
// Stack-machine operation sequencer: accepts one opcode, drives push/pop/tos
// strobes to the stack, tracks occupancy and reports result/err with a done pulse.
module stack_op_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_imm,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [DW-1:0]    depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_tos,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata
);

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [DW-1:0]    r_depth;
  logic             r_err;

  logic [WIDTH-1:0] w_alu;
  logic             w_reject;

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu)
  );

  // Occupancy check evaluated against the opcode being offered
  always_comb begin
    w_reject = 1'b0;
    if (r_depth < DW'(operand_need(op_code))) begin
      w_reject = 1'b1;
    end else if ((op_code == OP_PUSH) && (r_depth == DW'(DEPTH))) begin
      w_reject = 1'b1;
    end else begin
      w_reject = 1'b0;
    end
  end

  // Sequencer, operand capture, result and depth tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_imm    <= {WIDTH{1'b0}};
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_depth  <= {DW{1'b0}};
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_op  <= op_code;
            r_imm <= op_imm;
            r_err <= w_reject;
            if (w_reject) begin
              r_state <= ST_DONE;
            end else begin
              case (op_code)
                OP_NOP:  r_state <= ST_DONE;
                OP_PUSH: r_state <= ST_PUSH;
                default: r_state <= ST_POPA;
              endcase
            end
          end
        end
        ST_POPA: begin
          if (r_op != OP_TOS) begin
            r_depth <= r_depth - DW'(1'b1);
          end
          r_state <= ST_CAPA;
        end
        ST_CAPA: begin
          r_a <= stk_rdata;
          if ((r_op == OP_POP) || (r_op == OP_TOS)) begin
            r_result <= stk_rdata;
            r_state  <= ST_DONE;
          end else if (r_op == OP_NOT) begin
            r_state <= ST_PUSH;
          end else begin
            r_state <= ST_POPB;
          end
        end
        ST_POPB: begin
          r_depth <= r_depth - DW'(1'b1);
          r_state <= ST_CAPB;
        end
        ST_CAPB: begin
          r_b     <= stk_rdata;
          r_state <= ST_PUSH;
        end
        ST_PUSH: begin
          r_depth <= r_depth + DW'(1'b1);
          if (r_op != OP_PUSH) begin
            r_result <= w_alu;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes and status are pure decodes of registered state, so they are glitch-free
  assign op_ready  = (r_state == ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign result    = r_result;
  assign depth     = r_depth;
  assign stk_push  = (r_state == ST_PUSH);
  assign stk_pop   = ((r_state == ST_POPA) && (r_op != OP_TOS)) || (r_state == ST_POPB);
  assign stk_tos   = (r_state == ST_POPA) && (r_op == OP_TOS);
  assign stk_wdata = stk_push ? ((r_op == OP_PUSH) ? r_imm : w_alu) : {WIDTH{1'b0}};

endmodule
